div_sequencer: RTL and testbench

- Multi-cycle controller and datapath for the RV32M divide group: DIV, DIVU, REM and REMU.
- Sits beside the EX-stage ALU.
- Accepts a divide op issued from ID/EX and runs a radix-2 restoring shift-subtract loop over 32 cycles.
- Holds the pipeline with STALL until the result is ready, then returns it for the EX/MEM latch.

---
 rtl/div_sequencer_pkg.sv | 17 +
 rtl/div_step.sv | 21 ++
 rtl/div_sequencer.sv | 142 ++++++++++++++
 tb/tb_div_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_sequencer_pkg.sv
// Shared pipeline definitions for the divide sequencer: FSM state encoding and RV32M divide FUNC3 codes.
package div_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        INIT = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        FIN  = 3'd4
    } state_e;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift {rem,quo} left, trial-subtract the divisor, keep or restore.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] div_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;

    assign shifted = {rem_i, quo_i[XLEN-1]};
    // rem < div always holds, so a negative trial is fully captured by its top bit.
    assign trial   = shifted - {1'b0, div_i};
    assign rem_o   = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
    assign quo_o   = {quo_i[XLEN-2:0], ~trial[XLEN]};

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU/REM/REMU controller beside the EX-stage ALU; stalls the pipe until RESULT is ready.
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic [2:0]      FUNC3,
    input  logic [XLEN-1:0] OP1,
    input  logic [XLEN-1:0] OP2,
    input  logic            FLUSH,
    output logic            STALL,
    output logic            BUSY,
    output logic            DONE,
    output logic [XLEN-1:0] RESULT
);

    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]   quo_q, rem_q, div_q, op1_q, op2_q, result_q;
    logic [2:0]        func3_q;
    logic              qneg_q, rneg_q;

    logic              accept, is_signed, want_rem, div_zero, div_ovf;
    logic [XLEN-1:0]   op1_mag, op2_mag, rem_step, quo_step, quo_fix, rem_fix;

    assign accept    = (state_q == IDLE) & START & FUNC3[2] & ~FLUSH;
    assign is_signed = (func3_q == F3_DIV) | (func3_q == F3_REM);
    assign want_rem  = (func3_q == F3_REM) | (func3_q == F3_REMU);
    assign div_zero  = (op2_q == '0);
    assign div_ovf   = is_signed & (op1_q == SMIN) & (op2_q == '1);
    // -SMIN wraps back to SMIN, which is the correct unsigned magnitude.
    assign op1_mag   = (is_signed & op1_q[XLEN-1]) ? -op1_q : op1_q;
    assign op2_mag   = (is_signed & op2_q[XLEN-1]) ? -op2_q : op2_q;
    assign quo_fix   = qneg_q ? -quo_q : quo_q;
    assign rem_fix   = rneg_q ? -rem_q : rem_q;
    assign RESULT    = result_q;

    div_step #(.XLEN(XLEN)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .div_i (div_q),
        .rem_o (rem_step),
        .quo_o (quo_step)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (FLUSH) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (accept) state_d = INIT;
                INIT:    state_d = (div_zero | div_ovf) ? FIX : ITER;
                ITER:    if (cnt_q == '0) state_d = FIX;
                FIX:     state_d = FIN;
                FIN:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        STALL = 1'b0;
        BUSY  = (state_q != IDLE);
        DONE  = (state_q == FIN);
        case (state_q)
            IDLE:             STALL = accept;
            INIT, ITER, FIX:  STALL = ~FLUSH;
            default:          STALL = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cnt_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            div_q    <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            func3_q  <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        func3_q <= FUNC3;
                        op1_q   <= OP1;
                        op2_q   <= OP2;
                    end
                end
                INIT: begin
                    // Special cases preload the final answer and clear the signs so FIX passes them through.
                    if (div_zero) begin
                        quo_q  <= '1;
                        rem_q  <= op1_q;
                        qneg_q <= 1'b0;
                        rneg_q <= 1'b0;
                    end else if (div_ovf) begin
                        quo_q  <= SMIN;
                        rem_q  <= '0;
                        qneg_q <= 1'b0;
                        rneg_q <= 1'b0;
                    end else begin
                        quo_q  <= op1_mag;
                        div_q  <= op2_mag;
                        rem_q  <= '0;
                        qneg_q <= is_signed & (op1_q[XLEN-1] ^ op2_q[XLEN-1]);
                        rneg_q <= is_signed & op1_q[XLEN-1];
                        cnt_q  <= CNT_W'(XLEN - 1);
                    end
                end
                ITER: begin
                    rem_q <= rem_step;
                    quo_q <= quo_step;
                    cnt_q <= cnt_q - CNT_W'(1);
                end
                FIX: begin
                    if (!FLUSH) result_q <= want_rem ? rem_fix : quo_fix;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer: random and directed RV32M divides against an arithmetic reference model.
module tb_div_sequencer;
    import div_sequencer_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        START = 1'b0;
    logic [2:0]  FUNC3 = 3'b000;
    logic [31:0] OP1 = '0;
    logic [31:0] OP2 = '0;
    logic        FLUSH = 1'b0;
    logic        STALL, BUSY, DONE;
    logic [31:0] RESULT;

    typedef struct {
        logic [31:0] res;
        int          cyc;
        int          stall;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          stall_cnt = 0;
    logic [31:0] last_result = '0;

    div_sequencer dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .START  (START),
        .FUNC3  (FUNC3),
        .OP1    (OP1),
        .OP2    (OP2),
        .FLUSH  (FLUSH),
        .STALL  (STALL),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .RESULT (RESULT)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        return (b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Reference: RISC-V divide semantics via native integer division (truncating toward zero).
    function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int sa, sb_, sq, sr;
        bit rem_op = f3[1];
        if (b == 0) return rem_op ? a : 32'hFFFF_FFFF;
        if (!f3[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                return rem_op ? 32'h0 : 32'h8000_0000;
            sa = a; sb_ = b;
            sq = sa / sb_;
            sr = sa % sb_;
            return rem_op ? sr : sq;
        end
        return rem_op ? (a % b) : (a / b);
    endfunction

    always @(negedge CLK) begin
        if (!RESET) begin
            stall_cnt = 0;
        end else if (DONE) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("txn %s: RESULT=%h cycle=%0d stall_cycles=%0d", e.name, RESULT, cyc, stall_cnt);
                chk({e.name, "_result"}, RESULT, e.res);
                chk({e.name, "_done_cycle"}, 32'(cyc), 32'(e.cyc));
                chk({e.name, "_stall_cycles"}, 32'(stall_cnt), 32'(e.stall));
                last_result = e.res;
            end
            stall_cnt = 0;
        end else if (FLUSH) begin
            stall_cnt = 0;
        end else if (STALL) begin
            stall_cnt++;
        end
    end

    // Drives a request in the current cycle (call #2 after a rising edge); releases START after the edge.
    task automatic issue_now(input string name, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] b, input bit push);
        exp_t e;
        START = 1'b1; FUNC3 = f3; OP1 = a; OP2 = b; FLUSH = 1'b0;
        if (push) begin
            e.res   = ref_div(f3, a, b);
            e.cyc   = cyc + (is_special(f3, a, b) ? 3 : 35);
            e.stall = is_special(f3, a, b) ? 3 : 35;
            e.name  = name;
            sb.push_back(e);
        end
        #1 chk({name, "_stall_on_issue"}, 32'(STALL), 32'd1);
        @(posedge CLK); #2;
        START = 1'b0;
    endtask

    task automatic issue(input string name, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input bit push);
        @(posedge CLK); #2;
        issue_now(name, f3, a, b, push);
    endtask

    task automatic wait_done(input string name);
        bit seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge CLK);
            if (DONE) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_timeout: DONE=0 within 60 cycles, expected 1", name);
        end
    endtask

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("reset_stall", 32'(STALL), 32'd0);
        chk("reset_busy", 32'(BUSY), 32'd0);
        chk("reset_done", 32'(DONE), 32'd0);
        chk("reset_result", RESULT, 32'd0);
        @(posedge CLK); #2 RESET = 1'b1;

        // Non-divide FUNC3 must neither stall nor start.
        @(posedge CLK); #2;
        START = 1'b1; FUNC3 = 3'b000; OP1 = 32'd9; OP2 = 32'd3;
        #1 chk("nondiv_stall", 32'(STALL), 32'd0);
        @(posedge CLK); #2 START = 1'b0;
        #1 chk("nondiv_busy", 32'(BUSY), 32'd0);

        issue("divu_100_7", F3_DIVU, 32'd100, 32'd7, 1);           wait_done("divu_100_7");
        issue("remu_100_7", F3_REMU, 32'd100, 32'd7, 1);           wait_done("remu_100_7");
        issue("div_m7_2", F3_DIV, 32'hFFFF_FFF9, 32'd2, 1);        wait_done("div_m7_2");
        issue("rem_m7_2", F3_REM, 32'hFFFF_FFF9, 32'd2, 1);        wait_done("rem_m7_2");
        issue("div_5_0", F3_DIV, 32'd5, 32'd0, 1);                 wait_done("div_5_0");
        issue("remu_5_0", F3_REMU, 32'd5, 32'd0, 1);               wait_done("remu_5_0");
        issue("div_ovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1); wait_done("div_ovf");
        issue("rem_ovf", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1); wait_done("rem_ovf");
        issue("divu_min_m1", F3_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 1); wait_done("divu_min_m1");
        issue("rem_min_3", F3_REM, 32'h8000_0000, 32'd3, 1);       wait_done("rem_min_3");

        // FLUSH during iteration 10, then a new START in the very next cycle.
        issue("flushed", F3_DIVU, 32'd5000, 32'd3, 0);
        repeat (11) @(posedge CLK);
        #2 FLUSH = 1'b1;
        #1 chk("flush_stall", 32'(STALL), 32'd0);
        chk("flush_busy_before", 32'(BUSY), 32'd1);
        @(posedge CLK); #2 FLUSH = 1'b0;
        #0 chk("flush_busy_after", 32'(BUSY), 32'd0);
        chk("flush_done", 32'(DONE), 32'd0);
        chk("flush_result_held", RESULT, last_result);
        issue_now("after_flush", F3_DIVU, 32'd1000, 32'd10, 1);
        wait_done("after_flush");

        // FLUSH in FIN cannot suppress the DONE pulse.
        issue("flush_in_fin", F3_DIV, 32'd12, 32'hFFFF_FFFB, 1);
        repeat (34) @(posedge CLK);
        #2 FLUSH = 1'b1;
        #1 chk("fin_flush_stall", 32'(STALL), 32'd0);
        @(negedge CLK);
        @(posedge CLK); #2 FLUSH = 1'b0;

        // Asynchronous reset mid-ITER clears everything immediately.
        issue("reset_mid", F3_DIV, 32'd12345, 32'd67, 0);
        repeat (15) @(posedge CLK);
        #2 RESET = 1'b0;
        #1 chk("rst_mid_stall", 32'(STALL), 32'd0);
        chk("rst_mid_busy", 32'(BUSY), 32'd0);
        chk("rst_mid_done", 32'(DONE), 32'd0);
        chk("rst_mid_result", RESULT, 32'd0);
        last_result = '0;
        @(posedge CLK); #2 RESET = 1'b1;

        // START with different operands while busy must be ignored.
        issue("busy_ignore", F3_DIVU, 32'd1000, 32'd10, 1);
        repeat (3) @(posedge CLK);
        #2 START = 1'b1; FUNC3 = F3_REM; OP1 = 32'd77; OP2 = 32'd5;
        #1 chk("busy_start_busy", 32'(BUSY), 32'd1);
        repeat (10) @(posedge CLK);
        #2 START = 1'b0;
        wait_done("busy_ignore");

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  f3;
            logic [31:0] a, b;
            f3 = 3'($urandom_range(4, 7));
            a  = rnd_op();
            b  = rnd_op();
            issue($sformatf("rand%0d", i), f3, a, b, 1);
            wait_done($sformatf("rand%0d", i));
        end

        repeat (5) @(posedge CLK);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
